// File: rtl/alu_pkg.sv
// Shared widths and types for the operand-fetch stage and the ALU function units.
package alu_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_core.sv
// Register storage: one synchronous write port, two asynchronous read ports, R0 reads as zero.
module regfile_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned ADDR_W = alu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a_c,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a_c = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
        rd_data_b_c = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];
    end

endmodule

// File: rtl/regfile_operand_stage.sv
// Operand-fetch stage: reads two registers per request into a registered ALU operand slot,
// with write-back bypass on accept and operand refresh while the ALU stalls.
module regfile_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned ADDR_W = alu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs_a,
    input  logic [ADDR_W-1:0] rs_b,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [ADDR_W-1:0] hold_a;
    logic [ADDR_W-1:0] hold_b;

    logic              accept;
    logic              stall;
    logic              op_valid_nxt;
    logic [DATA_W-1:0] op_a_nxt;
    logic [DATA_W-1:0] op_b_nxt;
    logic [ADDR_W-1:0] hold_a_nxt;
    logic [ADDR_W-1:0] hold_b_nxt;

    regfile_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wb_en),
        .wr_addr     (wb_addr),
        .wr_data     (wb_data),
        .rd_addr_a   (rs_a),
        .rd_data_a_c (rd_a),
        .rd_addr_b   (rs_b),
        .rd_data_b_c (rd_b)
    );

    assign req_ready = !op_valid || op_ready;
    assign accept    = req_valid && req_ready;
    assign stall     = op_valid && !op_ready;

    // Next-state for the operand slot: accept (with bypass), stall refresh, or consume.
    always_comb begin
        op_valid_nxt = op_valid;
        op_a_nxt     = op_a;
        op_b_nxt     = op_b;
        hold_a_nxt   = hold_a;
        hold_b_nxt   = hold_b;

        if (accept) begin
            op_valid_nxt = 1'b1;
            hold_a_nxt   = rs_a;
            hold_b_nxt   = rs_b;
            op_a_nxt     = (wb_en && (rs_a != '0) && (wb_addr == rs_a)) ? wb_data : rd_a;
            op_b_nxt     = (wb_en && (rs_b != '0) && (wb_addr == rs_b)) ? wb_data : rd_b;
        end else if (stall) begin
            if (wb_en && (hold_a != '0) && (wb_addr == hold_a)) begin
                op_a_nxt = wb_data;
            end
            if (wb_en && (hold_b != '0) && (wb_addr == hold_b)) begin
                op_b_nxt = wb_data;
            end
        end else if (op_valid && op_ready) begin
            op_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            hold_a   <= '0;
            hold_b   <= '0;
        end else begin
            op_valid <= op_valid_nxt;
            op_a     <= op_a_nxt;
            op_b     <= op_b_nxt;
            hold_a   <= hold_a_nxt;
            hold_b   <= hold_b_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Directed vector bench for regfile_operand_stage: table of per-cycle stimulus and expected outputs.
module tb_regfile_operand_stage;
    import alu_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      req_valid;
    logic      req_ready;
    reg_addr_t rs_a;
    reg_addr_t rs_b;
    logic      op_valid;
    logic      op_ready;
    word_t     op_a;
    word_t     op_b;
    logic      wb_en;
    reg_addr_t wb_addr;
    word_t     wb_data;

    int n_vec;
    int n_err;

    typedef struct {
        logic      wb_en;
        reg_addr_t wb_addr;
        word_t     wb_data;
        logic      req_valid;
        reg_addr_t rs_a;
        reg_addr_t rs_b;
        logic      op_ready;
        logic      exp_rr;
        logic      exp_valid;
        word_t     exp_a;
        word_t     exp_b;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    regfile_operand_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rs_a      (rs_a),
        .rs_b      (rs_b),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input word_t act, input word_t exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        req_valid = 1'b0;
        rs_a      = '0;
        rs_b      = '0;
        op_ready  = 1'b0;
    endtask

    initial begin
        //           wb  addr   data      rv   rsa    rsb    ordy rr   vld  a         b
        vecs[0]  = '{1'b1, 4'd3, 16'h00FF, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 4'd5, 16'h0F0F, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'h0F0F};
        vecs[3]  = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0F0F};
        vecs[4]  = '{1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b1, 4'd7, 16'h1234, 1'b1, 4'd7, 4'd7, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234};
        vecs[6]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd7, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'h1234};
        vecs[7]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 4'd3, 1'b1, 1'b1, 1'b1, 16'h0F0F, 16'h00FF};
        vecs[8]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000};
        vecs[9]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'h00FF};
        vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 4'd7, 1'b1, 1'b1, 1'b1, 16'h0F0F, 16'h1234};
        vecs[11] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0F0F, 16'h1234};
        vecs[12] = '{1'b1, 4'd2, 16'h1111, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'h1234};
        vecs[13] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 4'd5, 1'b0, 1'b1, 1'b1, 16'h1111, 16'h0F0F};
        vecs[14] = '{1'b1, 4'd2, 16'hBEEF, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0F0F};
        vecs[15] = '{1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 4'd1, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'hAAAA};
        vecs[16] = '{1'b1, 4'd9, 16'h5555, 1'b1, 4'd9, 4'd2, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'hAAAA};
        vecs[17] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 4'd9, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h5555};
        vecs[18] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vecs[19] = '{1'b1, 4'd4, 16'h7777, 1'b1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h7777};

        n_vec = 0;
        n_err = 0;
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset op_valid", op_valid, 1'b0);
        check_word("reset op_a", op_a, 16'h0000);
        check_word("reset op_b", op_b, 16'h0000);
        n_vec++;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            wb_en     = vecs[i].wb_en;
            wb_addr   = vecs[i].wb_addr;
            wb_data   = vecs[i].wb_data;
            req_valid = vecs[i].req_valid;
            rs_a      = vecs[i].rs_a;
            rs_b      = vecs[i].rs_b;
            op_ready  = vecs[i].op_ready;
            #1;
            check_bit($sformatf("v%0d req_ready", i), req_ready, vecs[i].exp_rr);
            @(posedge clk);
            #1;
            check_bit($sformatf("v%0d op_valid", i), op_valid, vecs[i].exp_valid);
            check_word($sformatf("v%0d op_a", i), op_a, vecs[i].exp_a);
            check_word($sformatf("v%0d op_b", i), op_b, vecs[i].exp_b);
            n_vec++;
        end

        // Stalled with op_valid=1: reset must clear outputs without waiting for an edge.
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("async reset op_valid", op_valid, 1'b0);
        check_word("async reset op_a", op_a, 16'h0000);
        check_word("async reset op_b", op_b, 16'h0000);
        check_bit("async reset req_ready", req_ready, 1'b1);
        n_vec++;
        @(negedge clk);
        rst_n = 1'b1;

        // First request after release reads the cleared array.
        req_valid = 1'b1;
        rs_a      = 4'd3;
        rs_b      = 4'd5;
        op_ready  = 1'b1;
        @(posedge clk);
        #1;
        check_bit("post-reset op_valid", op_valid, 1'b1);
        check_word("post-reset op_a", op_a, 16'h0000);
        check_word("post-reset op_b", op_b, 16'h0000);
        n_vec++;

        drive_idle();
        op_ready = 1'b1;
        @(posedge clk);
        #1;
        check_bit("post-reset consume op_valid", op_valid, 1'b0);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_operand_stage.md
# regfile_operand_stage

- Operand-fetch stage directly upstream of the ALU: holds a 16 x 16-bit register file and reads two source registers per request.
- Presents them as registered operands `op_a`/`op_b` to the ALU function units (bitwise AND and siblings) over a valid/ready handshake.
- ALU results return on the write-back port; same-cycle and stalled-operand hazards are resolved internally, so the ALU always consumes current register values.

## Interface
- `DATA_W`, default 16: register and operand width.
- `ADDR_W`, default 4: register address width; `NUM_REGS` = 2**`ADDR_W`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  read request present.
- `req_ready`  out  1  stage can accept a request this cycle.
- `rs_a`  in  `ADDR_W`  source register for `op_a`.
- `rs_b`  in  `ADDR_W`  source register for `op_b`.
- `op_valid`  out  1  operands held for the ALU.
- `op_ready`  in  1  ALU consumes operands this cycle.
- `op_a`  out  `DATA_W`  operand A.
- `op_b`  out  `DATA_W`  operand B.
- `wb_en`  in  1  write-back strobe.
- `wb_addr`  in  `ADDR_W`  write-back destination.
- `wb_data`  in  `DATA_W`  write-back value.

## Operation
- Reset: all registers 0; `op_valid`=0, `op_a`=`op_b`=0, held source addresses 0.
- Register 0 is hardwired zero: writes to it are discarded, and reads return 0 with no bypass.
- `req_ready` = !`op_valid` || `op_ready`, a combinational pass-through. There is no combinational path from `req_valid` to `req_ready`.
- Accept (`req_valid` && `req_ready`):
  - the output register loads the read values;
  - `op_valid` is set to 1;
  - `rs_a`/`rs_b` are captured as held addresses.
- Consume without a new accept (`op_valid` && `op_ready` && !`req_valid`): `op_valid` goes to 0 and the data is left unchanged.
- Write: when `wb_en` is set and `wb_addr` is nonzero, the register file is updated at the clock edge.
- Bypass on accept: if `wb_en` is set and `wb_addr` == `rs_x` != 0 in the accepting cycle, `op_x` loads `wb_data` rather than the stale array value. Both operands bypass independently.
- Stall refresh: while `op_valid` && !`op_ready`, a write whose `wb_addr` matches a nonzero held address overwrites the corresponding `op_x` with `wb_data`. If both held addresses match, both operands update. `op_valid` is unchanged.
- Request ignored: when `req_ready`=0, `rs_a`/`rs_b` are ignored and may change freely.
- Upstream contract: `req_valid` with unstable `rs_*` while `req_ready`=0 is legal.
- Downstream contract: `op_a`/`op_b`/`op_valid` change only on accept, consume, or stall refresh.

## Timing
- Latency: 1 cycle. A request accepted at edge N gives `op_valid`=1 with data after edge N.
- Throughput: 1 request per cycle when `op_ready` is held at 1.
- Write-to-read: a write at edge N is visible to a request accepted at edge N (via bypass) and to every later request (via the array).
- Simultaneous consume + accept: the output register reloads and `op_valid` stays 1. There is no bubble.
- Reset asserted mid-transfer: outputs clear immediately and asynchronously. After deassertion, the first request is accepted on the next edge where `req_valid`=1.

## Structure
- Shared package `alu_pkg`: `DATA_W`, `ADDR_W`, `NUM_REGS`, and typedefs `reg_addr_t`/`word_t`. The ALU function units use the same package.
- One sub-module, `regfile_core`: a 16-entry storage array with one synchronous write port, two asynchronous read ports, and register 0 forced to 0.
- The top level holds the output register, held addresses, handshake, bypass and refresh logic.

## Test plan
- Reset, then write R3=0x00FF and R5=0x0F0F on consecutive cycles; request rs_a=3, rs_b=5 with op_ready=1 → next cycle op_valid=1, op_a=0x00FF, op_b=0x0F0F.
- Write R0=0xFFFF, then request rs_a=0, rs_b=0 → op_a=op_b=0x0000.
- In the same cycle: wb_en with R7=0x1234, and request rs_a=7, rs_b=7 → op_a=op_b=0x1234, not the old R7 value.
- Hold op_ready=0 with operands from R2 held, then write R2=0xBEEF → op_a becomes 0xBEEF, op_valid stays 1, and req_ready stays 0 until op_ready=1.
- Back-to-back: 4 requests on 4 consecutive cycles with op_ready=1 → 4 consecutive op_valid cycles, each with correct data and no bubbles.
- Assert rst_n=0 while op_valid=1 mid-stall → op_valid=0 and op_a=op_b=0 immediately; after release, a read of R3 returns 0.
